// File: rtl/fft8_pipe_ctrl_pkg.sv
// rtl/fft8_pipe_ctrl_pkg.sv - shared constants and helpers for the 8-point FFT sequencer
package fft8_pipe_ctrl_pkg;

  localparam int FFT_STAGES   = 3;
  localparam int FFT_CTRL_LAT = 4;

  typedef logic [2:0] inflight_t;

  function automatic inflight_t popcount4(input logic [3:0] b);
    return inflight_t'(b[0]) + inflight_t'(b[1]) + inflight_t'(b[2]) + inflight_t'(b[3]);
  endfunction

endpackage

// File: rtl/fft_tag_stage.sv
// rtl/fft_tag_stage.sv - one pipeline stage: valid bit plus frame payload with enable and clear
module fft_tag_stage
  import fft8_pipe_ctrl_pkg::*;
#(
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic          clr_i,
  input  logic          valid_i,
  input  logic [PW-1:0] pay_i,
  output logic          valid_o,
  output logic [PW-1:0] pay_o
);

  logic          valid_q, valid_d;
  logic [PW-1:0] pay_q, pay_d;

  // Clear wins over enable so an aborted frame never reaches the next stage.
  always_comb begin
    valid_d = valid_q;
    pay_d   = pay_q;
    if (clr_i) begin
      valid_d = 1'b0;
    end else if (en_i) begin
      valid_d = valid_i;
      pay_d   = pay_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pay_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pay_q   <= pay_d;
    end
  end

  assign valid_o = valid_q;
  assign pay_o   = pay_q;

endmodule

// File: rtl/fft8_pipe_ctrl.sv
// rtl/fft8_pipe_ctrl.sv - 8-point FFT pipeline sequencer; FFT_IFFT_EN adds inverse-transform tagging
module fft8_pipe_ctrl
  import fft8_pipe_ctrl_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             req_ready_o,
  input  logic             flush_i,
  output logic             load_en_o,
  output logic             butterfly0_ready_o,
  output logic             butterfly1_ready_o,
  output logic             butterfly2_ready_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [TAG_W-1:0] out_tag_o,
  output logic             busy_o,
  output logic [2:0]       inflight_o,
`ifdef FFT_IFFT_EN
  input  logic             req_inv_i,
  output logic             conj_in_o,
  output logic             out_inv_o,
`endif
  output logic [CNT_W-1:0] frame_cnt_o
);

`ifdef FFT_IFFT_EN
  localparam int PW = TAG_W + 1;
`else
  localparam int PW = TAG_W;
`endif

  logic                  advance, accept, step;
  logic [FFT_STAGES:0]   v_chain;
  logic [PW-1:0]         pay_chain [FFT_STAGES+1];
  logic                  out_valid_q, out_valid_d;
  logic [PW-1:0]         out_pay_q, out_pay_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  assign advance     = ~out_valid_q | out_ready_i;
  // Gating with rst_n keeps the capture strobe quiet while reset is held.
  assign req_ready_o = rst_n & advance & ~flush_i;
  assign accept      = req_valid_i & req_ready_o;
  assign load_en_o   = accept;
  assign step        = advance & ~flush_i;
  assign v_chain[0]  = accept;

`ifdef FFT_IFFT_EN
  assign pay_chain[0] = {req_inv_i, req_tag_i};
  assign conj_in_o    = accept & req_inv_i;
  assign out_inv_o    = out_pay_q[TAG_W];
`else
  assign pay_chain[0] = req_tag_i;
`endif

  for (genvar i = 0; i < FFT_STAGES; i++) begin : g_stage
    fft_tag_stage #(.PW(PW)) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (advance),
      .clr_i   (flush_i),
      .valid_i (v_chain[i]),
      .pay_i   (pay_chain[i]),
      .valid_o (v_chain[i+1]),
      .pay_o   (pay_chain[i+1])
    );
  end

  assign butterfly0_ready_o = v_chain[1] & step;
  assign butterfly1_ready_o = v_chain[2] & step;
  assign butterfly2_ready_o = v_chain[3] & step;

  // The slot reloads from the last stage whenever it advances, so a draining
  // handshake and an arriving frame share one edge without a bubble.
  always_comb begin
    out_valid_d = out_valid_q;
    out_pay_d   = out_pay_q;
    cnt_d       = cnt_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (advance) begin
      out_valid_d = v_chain[FFT_STAGES];
      if (v_chain[FFT_STAGES]) begin
        out_pay_d = pay_chain[FFT_STAGES];
      end
    end
    if (out_valid_q && out_ready_i && !flush_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_pay_q   <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_pay_q   <= out_pay_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_tag_o   = out_pay_q[TAG_W-1:0];
  assign frame_cnt_o = cnt_q;
  assign inflight_o  = popcount4({v_chain[FFT_STAGES:1], out_valid_q});
  assign busy_o      = |{v_chain[FFT_STAGES:1], out_valid_q};

endmodule

// File: tb/tb_fft8_pipe_ctrl.sv
// tb/tb_fft8_pipe_ctrl.sv - scoreboard bench for the FFT pipeline sequencer
module tb_fft8_pipe_ctrl;

  localparam int TAG_W = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid_i = 1'b0;
  logic [TAG_W-1:0] req_tag_i = '0;
  logic             flush_i = 1'b0;
  logic             out_ready_i = 1'b0;
  logic             req_ready_o, load_en_o;
  logic             butterfly0_ready_o, butterfly1_ready_o, butterfly2_ready_o;
  logic             out_valid_o, busy_o;
  logic [TAG_W-1:0] out_tag_o;
  logic [2:0]       inflight_o;
  logic [CNT_W-1:0] frame_cnt_o;
`ifdef FFT_IFFT_EN
  logic             req_inv_i = 1'b0;
  logic             conj_in_o, out_inv_o;
`endif

  fft8_pipe_ctrl #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .req_valid_i        (req_valid_i),
    .req_tag_i          (req_tag_i),
    .req_ready_o        (req_ready_o),
    .flush_i            (flush_i),
    .load_en_o          (load_en_o),
    .butterfly0_ready_o (butterfly0_ready_o),
    .butterfly1_ready_o (butterfly1_ready_o),
    .butterfly2_ready_o (butterfly2_ready_o),
    .out_valid_o        (out_valid_o),
    .out_ready_i        (out_ready_i),
    .out_tag_o          (out_tag_o),
    .busy_o             (busy_o),
    .inflight_o         (inflight_o),
`ifdef FFT_IFFT_EN
    .req_inv_i          (req_inv_i),
    .conj_in_o          (conj_in_o),
    .out_inv_o          (out_inv_o),
`endif
    .frame_cnt_o        (frame_cnt_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  logic [TAG_W:0] sb[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every output handshake must match the oldest expected frame.
  always @(negedge clk) begin
    logic [TAG_W:0] exp;
    if (rst_n && out_valid_o && out_ready_i && !flush_i) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: out_tag_o=%0d with no frame expected", out_tag_o);
      end else begin
        exp = sb.pop_front();
        exp_cnt++;
        if (out_tag_o !== exp[TAG_W-1:0]) begin
          errors++;
          $display("FAIL sb_tag: out_tag_o=%0d expected %0d", out_tag_o, exp[TAG_W-1:0]);
        end
`ifdef FFT_IFFT_EN
        checks++;
        if (out_inv_o !== exp[TAG_W]) begin
          errors++;
          $display("FAIL sb_inv: out_inv_o=%0b expected %0b", out_inv_o, exp[TAG_W]);
        end
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req_valid_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid_o, out_tag_o, frame_cnt_o, inflight_o, busy_o, butterfly0_ready_o,
         butterfly1_ready_o, butterfly2_ready_o, req_ready_o, load_en_o} !== '0) begin
      errors++;
      $display("FAIL reset_state: vld=%0b tag=%0d cnt=%0d infl=%0d busy=%0b bf=%0b%0b%0b rdy=%0b ld=%0b expected all 0",
               out_valid_o, out_tag_o, frame_cnt_o, inflight_o, busy_o, butterfly0_ready_o,
               butterfly1_ready_o, butterfly2_ready_o, req_ready_o, load_en_o);
    end
    req_valid_i = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: req_ready_o=%0b expected 1", req_ready_o);
    end
  endtask

  task automatic test_single();
    tick();
    out_ready_i = 1'b1;
    req_valid_i = 1'b1;
    req_tag_i   = 4'd5;
    @(negedge clk);
    checks++;
    if ({req_ready_o, load_en_o} !== 2'b11) begin
      errors++;
      $display("FAIL single_accept: rdy=%0b ld=%0b expected 1 1", req_ready_o, load_en_o);
    end
    sb.push_back({1'b0, 4'd5});
    tick();
    req_valid_i = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      logic [3:0] exp_v;
      exp_v = {k == 1, k == 2, k == 3, k == 4};
      @(negedge clk);
      checks++;
      if ({butterfly0_ready_o, butterfly1_ready_o, butterfly2_ready_o, out_valid_o} !== exp_v) begin
        errors++;
        $display("FAIL single_strobe_T+%0d: bf0/bf1/bf2/vld=%b expected %b", k,
                 {butterfly0_ready_o, butterfly1_ready_o, butterfly2_ready_o, out_valid_o}, exp_v);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (out_valid_o !== 1'b0 || frame_cnt_o !== 16'd1) begin
      errors++;
      $display("FAIL single_done: vld=%0b cnt=%0d expected 0 1", out_valid_o, frame_cnt_o);
    end
  endtask

  task automatic test_back_to_back();
    int max_infl = 0;
    int n_out = 0;
    int first = -1;
    int last = -1;
    for (int c = 0; c < 16; c++) begin
      tick();
      req_valid_i = (c < 6);
      req_tag_i   = 4'(c);
      @(negedge clk);
      if (c < 6) begin
        checks++;
        if (req_ready_o !== 1'b1) begin
          errors++;
          $display("FAIL b2b_ready_%0d: req_ready_o=%0b expected 1", c, req_ready_o);
        end
        sb.push_back({1'b0, 4'(c)});
      end
      if (int'(inflight_o) > max_infl) max_infl = int'(inflight_o);
      if (out_valid_o === 1'b1) begin
        n_out++;
        if (first < 0) first = c;
        last = c;
      end
    end
    req_valid_i = 1'b0;
    checks++;
    if (n_out != 6 || last - first != 5 || first != 4) begin
      errors++;
      $display("FAIL b2b_outputs: count=%0d first=%0d last=%0d expected 6 4 9", n_out, first, last);
    end
    checks++;
    if (max_infl != 4) begin
      errors++;
      $display("FAIL b2b_inflight_max: %0d expected 4", max_infl);
    end
    checks++;
    if (frame_cnt_o !== CNT_W'(exp_cnt) || sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: cnt=%0d pending=%0d expected %0d 0", frame_cnt_o, sb.size(), exp_cnt);
    end
  endtask

  task automatic test_backpressure();
    int n_valid = 0;
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      req_valid_i = 1'b1;
      req_tag_i   = 4'(8 + i);
      @(negedge clk);
      sb.push_back({1'b0, 4'(8 + i)});
    end
    tick();
    out_ready_i = 1'b0;
    req_tag_i   = 4'd15;
    for (int s = 0; s < 10; s++) begin
      @(negedge clk);
      checks++;
      if ({req_ready_o, load_en_o, butterfly0_ready_o, butterfly1_ready_o, butterfly2_ready_o} !== 5'b0 ||
          out_valid_o !== 1'b1 || out_tag_o !== 4'd8 || inflight_o !== 3'd4) begin
        errors++;
        $display("FAIL stall_%0d: rdy=%0b ld=%0b bf=%0b%0b%0b vld=%0b tag=%0d infl=%0d expected 0 0 000 1 8 4",
                 s, req_ready_o, load_en_o, butterfly0_ready_o, butterfly1_ready_o, butterfly2_ready_o,
                 out_valid_o, out_tag_o, inflight_o);
      end
      tick();
    end
    req_valid_i = 1'b0;
    out_ready_i = 1'b1;
    for (int d = 0; d < 8; d++) begin
      @(negedge clk);
      if (d < 4 && out_valid_o === 1'b1) n_valid++;
      tick();
    end
    checks++;
    if (n_valid != 4 || sb.size() != 0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL drain: valid_cycles=%0d pending=%0d busy=%0b expected 4 0 0", n_valid, sb.size(), busy_o);
    end
  endtask

  task automatic test_flush();
    int c0;
    out_ready_i = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      req_valid_i = 1'b1;
      req_tag_i   = 4'(i);
      @(negedge clk);
      sb.push_back({1'b0, 4'(i)});
    end
    tick();
    flush_i   = 1'b1;
    req_tag_i = 4'd7;
    c0 = exp_cnt;
    @(negedge clk);
    checks++;
    if ({req_ready_o, load_en_o, butterfly0_ready_o, butterfly1_ready_o, butterfly2_ready_o} !== 5'b0) begin
      errors++;
      $display("FAIL flush_cycle: rdy=%0b ld=%0b bf=%0b%0b%0b expected all 0",
               req_ready_o, load_en_o, butterfly0_ready_o, butterfly1_ready_o, butterfly2_ready_o);
    end
    tick();
    flush_i     = 1'b0;
    req_valid_i = 1'b0;
    sb.delete();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (inflight_o !== 3'd0 || busy_o !== 1'b0 || out_valid_o !== 1'b0 || frame_cnt_o !== CNT_W'(c0)) begin
        errors++;
        $display("FAIL flush_after_%0d: infl=%0d busy=%0b vld=%0b cnt=%0d expected 0 0 0 %0d",
                 k, inflight_o, busy_o, out_valid_o, frame_cnt_o, c0);
      end
      tick();
    end
    req_valid_i = 1'b1;
    req_tag_i   = 4'd4;
    @(negedge clk);
    sb.push_back({1'b0, 4'd4});
    for (int k = 0; k < 4; k++) begin
      tick();
      req_valid_i = 1'b0;
    end
    flush_i = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid_o !== 1'b1 || out_tag_o !== 4'd4) begin
      errors++;
      $display("FAIL flush_slot_setup: vld=%0b tag=%0d expected 1 4", out_valid_o, out_tag_o);
    end
    tick();
    flush_i = 1'b0;
    sb.delete();
    @(negedge clk);
    checks++;
    if (frame_cnt_o !== CNT_W'(c0) || out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop_uncounted: cnt=%0d vld=%0b expected %0d 0", frame_cnt_o, out_valid_o, c0);
    end
  endtask

  task automatic test_async_reset();
    int lat = -1;
    out_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      req_valid_i = 1'b1;
      req_tag_i   = 4'(i);
      @(negedge clk);
      sb.push_back({1'b0, 4'(i)});
    end
    tick();
    req_valid_i = 1'b0;
    out_ready_i = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid_o, out_tag_o, frame_cnt_o, inflight_o, busy_o, butterfly0_ready_o,
         butterfly1_ready_o, butterfly2_ready_o, req_ready_o, load_en_o} !== '0) begin
      errors++;
      $display("FAIL async_reset: vld=%0b tag=%0d cnt=%0d infl=%0d busy=%0b rdy=%0b expected all 0",
               out_valid_o, out_tag_o, frame_cnt_o, inflight_o, busy_o, req_ready_o);
    end
    sb.delete();
    exp_cnt = 0;
    tick();
    tick();
    rst_n = 1'b1;
    out_ready_i = 1'b1;
    tick();
    req_valid_i = 1'b1;
    req_tag_i   = 4'd9;
    @(negedge clk);
    sb.push_back({1'b0, 4'd9});
    tick();
    req_valid_i = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (out_valid_o === 1'b1 && lat < 0) lat = k;
      tick();
    end
    checks++;
    if (lat != 4 || frame_cnt_o !== 16'd1) begin
      errors++;
      $display("FAIL post_reset_frame: latency=%0d cnt=%0d expected 4 1", lat, frame_cnt_o);
    end
  endtask

`ifdef FFT_IFFT_EN
  task automatic test_ifft();
    logic [2:0] pat;
    pat = 3'b101;
    out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      req_valid_i = 1'b1;
      req_tag_i   = 4'(i + 1);
      req_inv_i   = pat[i];
      @(negedge clk);
      checks++;
      if (conj_in_o !== pat[i]) begin
        errors++;
        $display("FAIL conj_in_%0d: conj_in_o=%0b expected %0b", i, conj_in_o, pat[i]);
      end
      sb.push_back({pat[i], 4'(i + 1)});
    end
    tick();
    req_valid_i = 1'b0;
    req_inv_i   = 1'b0;
    for (int k = 0; k < 8; k++) tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
`ifdef FFT_IFFT_EN
    test_ifft();
`endif
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d frames never produced, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
